hdmi_line_fetch: RTL



---
 rtl/hdmi_line_fetch_if.sv | 27 ++
 rtl/hdmi_line_fetch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_line_fetch_if.sv
// Frame-buffer read bus between the line fetcher (master) and the memory (slave).
// Requests complete on mem_gnt; responses come back in request order.
interface hdmi_line_fetch_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [23:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/hdmi_line_fetch.sv
// Ping-pong line buffer between the frame-buffer read bus and the HDMI pixel path.
// The front bank is displayed while the next line is fetched into the back bank.
// A de rising edge swaps the banks and schedules the fetch of the following line.
module hdmi_line_fetch #(
  parameter int                H_ACTIVE       = 1280,
  parameter int                V_ACTIVE       = 720,
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] FB_BASE        = 32'h0000_0000,
  parameter int                LINE_STRIDE    = 5120,
  parameter int                MAX_OUT        = 4,
  parameter logic [23:0]       UNDERRUN_COLOR = 24'hFF00FF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       h_pos,
  input  logic [11:0]       v_pos,
  input  logic              de,
  output logic [23:0]       pixel_data,
  hdmi_line_fetch_if.master mem,
  output logic              underrun,
  input  logic              underrun_clr
);

  // x and fill count 0..H_ACTIVE inclusive; RAM index only needs 0..H_ACTIVE-1
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int RW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_reg;
  logic              fetch_pending_reg;
  logic [11:0]       fetch_line_reg;
  logic [ADDR_W-1:0] line_base_reg;
  logic [XW-1:0]     x_reg;
  logic [3:0]        out_reg;
  logic              abort_reg;
  logic              front_reg;
  logic              fetch_bank_reg;
  logic              de_d_reg;
  logic              underrun_reg;

  logic [11:0]       tag_reg       [2];
  logic              tag_valid_reg [2];
  logic [XW-1:0]     fill_reg      [2];

  logic              sel_hit_reg;
  logic              sel_ur_reg;
  logic              rd_bank_reg;

  logic              line_start;
  logic              issue_ok;
  logic              accept;
  logic              rsp;
  logic              wr_en;
  logic [11:0]       next_line;
  logic              front_now;
  logic              front_ok;
  logic              in_range;
  logic              pix_hit;
  logic [RW-1:0]     rd_addr;
  logic [RW-1:0]     wr_addr;

  assign line_start = de && !de_d_reg;

  // Request stays asserted (with a stable address) until granted: x only moves on
  // a grant and the outstanding count can only fall while waiting.
  assign issue_ok     = (state_reg == S_ISSUE) && (x_reg < XW'(H_ACTIVE)) && (out_reg < 4'(MAX_OUT));
  assign mem.mem_req  = issue_ok;
  assign mem.mem_addr = line_base_reg + ADDR_W'({x_reg, 2'b00});

  assign accept = issue_ok && mem.mem_gnt;
  // Stray responses with nothing outstanding are ignored entirely
  assign rsp    = mem.mem_rvalid && (out_reg != 4'd0);
  // Responses belonging to an aborted fetch are counted but never stored
  assign wr_en  = rsp && !abort_reg && !line_start;

  assign next_line = (v_pos >= 12'(V_ACTIVE - 1)) ? 12'd0 : v_pos + 12'd1;

  // The bank shown on the line-start cycle is already the newly swapped one
  assign front_now = line_start ? ~front_reg : front_reg;
  assign front_ok  = tag_valid_reg[~front_reg] && (tag_reg[~front_reg] == v_pos) &&
                     (fill_reg[~front_reg] == XW'(H_ACTIVE));

  assign in_range = 32'(h_pos) < H_ACTIVE;
  assign pix_hit  = de && in_range && (tag_reg[front_now] == v_pos) &&
                    (32'(h_pos) < 32'(fill_reg[front_now]));
  assign rd_addr  = RW'(h_pos);
  assign wr_addr  = RW'(fill_reg[fetch_bank_reg]);

  // Fetch FSM, bank bookkeeping and line-start handling
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= S_IDLE;
      fetch_pending_reg <= 1'b1;
      fetch_line_reg    <= 12'd0;
      line_base_reg     <= '0;
      x_reg             <= '0;
      out_reg           <= 4'd0;
      abort_reg         <= 1'b0;
      front_reg         <= 1'b1;
      fetch_bank_reg    <= 1'b0;
      de_d_reg          <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        tag_reg[i]       <= 12'd0;
        tag_valid_reg[i] <= 1'b0;
        fill_reg[i]      <= '0;
      end
    end else begin
      de_d_reg <= de;
      out_reg  <= out_reg + 4'(accept) - 4'(rsp);
      if (accept) begin
        x_reg <= x_reg + XW'(1);
      end
      if (wr_en) begin
        fill_reg[fetch_bank_reg] <= fill_reg[fetch_bank_reg] + XW'(1);
      end
      if (line_start) begin
        front_reg                <= ~front_reg;
        fetch_pending_reg        <= 1'b1;
        fetch_line_reg           <= next_line;
        tag_valid_reg[front_reg] <= 1'b0;
        if (state_reg != S_IDLE) begin
          state_reg <= S_DRAIN;
          abort_reg <= 1'b1;
        end
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (fetch_pending_reg) begin
              fetch_pending_reg         <= 1'b0;
              line_base_reg             <= FB_BASE + ADDR_W'(fetch_line_reg) * ADDR_W'(LINE_STRIDE);
              x_reg                     <= '0;
              fill_reg[~front_reg]      <= '0;
              tag_reg[~front_reg]       <= fetch_line_reg;
              tag_valid_reg[~front_reg] <= 1'b0;
              fetch_bank_reg            <= ~front_reg;
              abort_reg                 <= 1'b0;
              state_reg                 <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (x_reg == XW'(H_ACTIVE)) begin
              state_reg <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (out_reg == 4'd0) begin
              if (!abort_reg) begin
                tag_valid_reg[fetch_bank_reg] <= 1'b1;
              end
              state_reg <= S_IDLE;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  // Sticky underrun: a set on a line start wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_reg <= 1'b0;
    end else if (line_start && !front_ok) begin
      underrun_reg <= 1'b1;
    end else if (underrun_clr) begin
      underrun_reg <= 1'b0;
    end
  end

  // Output-select pipeline stage aligned with the registered RAM read
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_hit_reg <= 1'b0;
      sel_ur_reg  <= 1'b0;
      rd_bank_reg <= 1'b0;
    end else begin
      sel_hit_reg <= pix_hit;
      sel_ur_reg  <= de && !pix_hit;
      rd_bank_reg <= front_now;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [23:0] ram [H_ACTIVE];
      logic [23:0] q_reg;

      // One write port from the fetch side, one registered read port for display
      always_ff @(posedge clk) begin
        if (wr_en && (fetch_bank_reg == 1'(gi))) begin
          ram[wr_addr] <= mem.mem_rdata;
        end
        if (pix_hit && (front_now == 1'(gi))) begin
          q_reg <= ram[rd_addr];
        end
      end
    end
  endgenerate

  assign pixel_data = sel_hit_reg ? (rd_bank_reg ? g_bank[1].q_reg : g_bank[0].q_reg) :
                      sel_ur_reg  ? UNDERRUN_COLOR : 24'd0;
  assign underrun   = underrun_reg;

endmodule
